// File: rtl/fifo_byte_serializer_pkg.sv
// Shared definitions for the FWFT FIFO byte serializer: byte width, FSM encoding, word sizing.
package fifo_byte_serializer_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic int word_bytes(input int data_width);
        return (2 * data_width) / BYTE_W;
    endfunction

endpackage

// File: rtl/fifo_byte_serializer.sv
// Pops {I,Q} words from an FWFT FIFO and streams them MSB byte first; first byte one cycle after the pop.
// Holds byte/sof while valid & ~ready; next word loads on the last-byte accept with no bubble.
module fifo_byte_serializer
    import fifo_byte_serializer_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int UNDER_CNT_W = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     enable_i,
    input  logic                     fifo_empty_i,
    input  logic [2*DATA_WIDTH-1:0]  fifo_data_i,
    output logic                     fifo_rd_en_o,
    output logic [BYTE_W-1:0]        byte_o,
    output logic                     byte_valid_o,
    input  logic                     byte_ready_i,
    output logic                     sof_o,
    output logic                     busy_o,
    output logic [UNDER_CNT_W-1:0]   underrun_cnt_o
);

    localparam int WORD_W     = 2 * DATA_WIDTH;
    localparam int WORD_BYTES = word_bytes(DATA_WIDTH);
    localparam int IDX_W      = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORD_BYTES - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [WORD_W-1:0]      shreg_q;
    logic [IDX_W-1:0]       idx_q;
    logic                   sof_q;
    logic                   armed_q;
    logic                   latched_q;
    logic [UNDER_CNT_W-1:0] under_cnt_q;

    logic accept;
    logic last_accept;
    logic boundary;
    logic load;
    logic underrun;

    always_comb begin
        state_d     = state_q;
        accept      = (state_q == ST_SHIFT) && byte_ready_i;
        last_accept = accept && (idx_q == LAST_IDX);
        boundary    = (state_q == ST_IDLE) || last_accept;
        load        = enable_i && !fifo_empty_i && boundary;
        // One count per empty episode: latched blocks repeats until the next load.
        underrun    = armed_q && enable_i && fifo_empty_i && boundary && !latched_q;
        if (load) begin
            state_d = ST_SHIFT;
        end else if (last_accept) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shreg_q     <= '0;
            idx_q       <= '0;
            sof_q       <= 1'b0;
            armed_q     <= 1'b0;
            latched_q   <= 1'b0;
            under_cnt_q <= '0;
        end else begin
            if (load) begin
                shreg_q <= fifo_data_i;
                idx_q   <= '0;
                sof_q   <= 1'b1;
            end else if (accept && !last_accept) begin
                shreg_q <= {shreg_q[WORD_W-BYTE_W-1:0], {BYTE_W{1'b0}}};
                idx_q   <= idx_q + 1'b1;
                sof_q   <= 1'b0;
            end else if (last_accept) begin
                sof_q   <= 1'b0;
            end

            // Disarm while idle and disabled so a fresh enable ignores the initially empty FIFO.
            if (load) begin
                armed_q <= 1'b1;
            end else if ((state_q == ST_IDLE) && !enable_i) begin
                armed_q <= 1'b0;
            end

            if (load) begin
                latched_q <= 1'b0;
            end else if (underrun) begin
                latched_q <= 1'b1;
            end

            if (underrun && (under_cnt_q != '1)) begin
                under_cnt_q <= under_cnt_q + 1'b1;
            end
        end
    end

    assign fifo_rd_en_o   = load && !rst_i;
    assign byte_o         = shreg_q[WORD_W-1 -: BYTE_W];
    assign byte_valid_o   = (state_q == ST_SHIFT);
    assign busy_o         = (state_q == ST_SHIFT);
    assign sof_o          = sof_q;
    assign underrun_cnt_o = under_cnt_q;

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Directed bench for fifo_byte_serializer: behavioural FWFT FIFO, byte scoreboard, saturation twin.
module tb_fifo_byte_serializer;

    typedef struct {
        logic [7:0] b;
        logic       sof;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        enable;
    logic        fifo_empty;
    logic [31:0] fifo_data;
    logic        rd_en;
    logic [7:0]  byte_dat;
    logic        valid;
    logic        ready;
    logic        sof;
    logic        busy;
    logic [15:0] cnt;

    logic        rd_en_s;
    logic [7:0]  byte_s;
    logic        valid_s;
    logic        sof_s;
    logic        busy_s;
    logic [1:0]  cnt_s;

    logic [31:0] fifo_q[$];
    exp_t        exp_q[$];

    int checks = 0;
    int errors = 0;
    int rd_cnt = 0;
    int acc_mod = 0;
    int ready_mode = 0;
    logic pop_pending = 1'b0;

    fifo_byte_serializer #(.DATA_WIDTH(16), .UNDER_CNT_W(16)) dut (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .fifo_empty_i(fifo_empty),
        .fifo_data_i(fifo_data), .fifo_rd_en_o(rd_en), .byte_o(byte_dat),
        .byte_valid_o(valid), .byte_ready_i(ready), .sof_o(sof), .busy_o(busy),
        .underrun_cnt_o(cnt)
    );

    fifo_byte_serializer #(.DATA_WIDTH(16), .UNDER_CNT_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst), .enable_i(enable), .fifo_empty_i(fifo_empty),
        .fifo_data_i(fifo_data), .fifo_rd_en_o(rd_en_s), .byte_o(byte_s),
        .byte_valid_o(valid_s), .byte_ready_i(ready), .sof_o(sof_s), .busy_o(busy_s),
        .underrun_cnt_o(cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic fifo_refresh();
        fifo_empty = (fifo_q.size() == 0);
        fifo_data  = (fifo_q.size() == 0) ? 32'h0 : fifo_q[0];
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        for (int i = 0; i < 4; i++) begin
            exp_t e;
            e.b   = w[31-8*i -: 8];
            e.sof = (i == 0);
            exp_q.push_back(e);
        end
        fifo_refresh();
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        step();
        rst    = 1'b1;
        enable = 1'b0;
        fifo_q.delete();
        exp_q.delete();
        fifo_refresh();
        step();
        step();
        rst    = 1'b0;
        rd_cnt = 0;
    endtask

    // Wait until the DUT is idle and at most 'remain' expected bytes are still outstanding.
    task automatic drain(input string tag, input int max_cycles, input int remain);
        int n = 0;
        while ((exp_q.size() > remain || valid !== 1'b0) && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(n < max_cycles), 64'd1);
    endtask

    // FWFT FIFO model: pop decided at the falling edge, applied just after the rising edge.
    always @(posedge clk) begin
        #1;
        if (pop_pending && fifo_q.size() > 0) void'(fifo_q.pop_front());
        fifo_refresh();
    end

    initial begin
        ready = 1'b1;
        forever begin
            int pat = 0;
            @(posedge clk);
            #1;
            case (ready_mode)
                1: begin
                    ready = (pat == 0);
                    pat = (pat + 1) % 3;
                end
                2: ready = 1'($urandom_range(0, 1));
                default: ready = 1'b1;
            endcase
        end
    end

    // Scoreboard monitor: every valid byte must equal the head of exp_q; pop only on accept.
    always @(negedge clk) begin
        if (rst) begin
            acc_mod = 0;
        end else begin
            if (rd_en) begin
                rd_cnt++;
                chk("rd_en_while_empty", 64'(fifo_empty), 64'd0);
                if (valid) chk("pop_before_last_accept", {62'd0, ready, (acc_mod == 3)}, 64'd3);
            end
            chk("busy_eq_valid", 64'(busy), 64'(valid));
            if (valid) begin
                chk("unexpected_byte", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    chk("byte", 64'(byte_dat), 64'(exp_q[0].b));
                    chk("sof", 64'(sof), 64'(exp_q[0].sof));
                    if (ready) begin
                        void'(exp_q.pop_front());
                        acc_mod = (acc_mod + 1) % 4;
                    end
                end
            end
        end
        pop_pending = rd_en;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst    = 1'b1;
        enable = 1'b0;
        fifo_refresh();
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_byte", 64'(byte_dat), 64'd0);
        chk("rst_valid", 64'(valid), 64'd0);
        chk("rst_sof", 64'(sof), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_cnt", 64'(cnt), 64'd0);
        chk("rst_rd_en", 64'(rd_en), 64'd0);

        // T1 single word
        do_reset();
        push_word(32'h1234ABCD);
        enable = 1'b1;
        @(negedge clk);
        chk("t1_rd_en", 64'(rd_en), 64'd1);
        chk("t1_valid_pre", 64'(valid), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t1_valid", 64'(valid), 64'd1);
            chk("t1_rd_en_idle", 64'(rd_en), 64'd0);
        end
        @(negedge clk);
        chk("t1_valid_post", 64'(valid), 64'd0);
        chk("t1_rd_cnt", 64'(rd_cnt), 64'd1);
        chk("t1_exp_left", 64'(exp_q.size()), 64'd0);
        chk("t1_cnt", 64'(cnt), 64'd1);

        // T2 back-to-back words, no bubble
        do_reset();
        push_word(32'hA1B2C3D4);
        push_word(32'h55667788);
        push_word(32'h0F1E2D3C);
        enable = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("t2_contiguous", 64'(valid), 64'd1);
        end
        @(negedge clk);
        chk("t2_valid_post", 64'(valid), 64'd0);
        chk("t2_rd_cnt", 64'(rd_cnt), 64'd3);
        repeat (5) @(negedge clk);
        chk("t2_cnt", 64'(cnt), 64'd1);
        chk("t2_exp_left", 64'(exp_q.size()), 64'd0);

        // T3 backpressure: fixed 1,0,0 pattern then random ready
        do_reset();
        ready_mode = 1;
        push_word(32'hDEADBEEF);
        push_word(32'h01020304);
        enable = 1'b1;
        drain("t3_drain", 200, 0);
        chk("t3_rd_cnt", 64'(rd_cnt), 64'd2);
        chk("t3_cnt", 64'(cnt), 64'd1);
        ready_mode = 2;
        step();
        push_word(32'hCAFEF00D);
        push_word(32'h89ABCDEF);
        push_word(32'h13579BDF);
        drain("t3_rand_drain", 400, 0);
        chk("t3_rand_rd_cnt", 64'(rd_cnt), 64'd5);
        chk("t3_rand_cnt", 64'(cnt), 64'd2);
        ready_mode = 0;

        // T4 underrun counted once per empty episode
        do_reset();
        enable = 1'b1;
        repeat (5) @(negedge clk);
        chk("t4_fresh_enable", 64'(cnt), 64'd0);
        step();
        push_word(32'h11223344);
        drain("t4_drain_a", 50, 0);
        chk("t4_cnt_a", 64'(cnt), 64'd1);
        repeat (10) @(negedge clk);
        chk("t4_cnt_idle", 64'(cnt), 64'd1);
        step();
        push_word(32'h55AA55AA);
        @(negedge clk);
        chk("t4_cnt_b_load", 64'(cnt), 64'd1);
        drain("t4_drain_b", 50, 0);
        chk("t4_cnt_b", 64'(cnt), 64'd2);

        // Saturation: five episodes, 2-bit counter sticks at 3
        do_reset();
        enable = 1'b1;
        for (int e = 0; e < 5; e++) begin
            step();
            push_word(32'h10203040 + 32'(e));
            drain("sat_drain", 50, 0);
        end
        chk("sat_cnt_wide", 64'(cnt), 64'd5);
        chk("sat_cnt_narrow", 64'(cnt_s), 64'd3);

        // T5 disable mid-word: word completes, no further pops
        do_reset();
        push_word(32'hAABBCCDD);
        push_word(32'hEEFF0011);
        push_word(32'h22334455);
        enable = 1'b1;
        step();
        step();
        step();
        enable = 1'b0;
        drain("t5_drain", 50, 8);
        repeat (5) @(negedge clk);
        chk("t5_exp_left", 64'(exp_q.size()), 64'd8);
        chk("t5_fifo_left", 64'(fifo_q.size()), 64'd2);
        chk("t5_rd_cnt", 64'(rd_cnt), 64'd1);
        chk("t5_cnt", 64'(cnt), 64'd0);
        step();
        enable = 1'b1;
        drain("t5_resume", 100, 0);
        chk("t5_resume_rd_cnt", 64'(rd_cnt), 64'd3);
        chk("t5_resume_cnt", 64'(cnt), 64'd1);

        // T6 reset mid-word: partial word dropped, next word starts clean
        do_reset();
        push_word(32'h9876FEDC);
        push_word(32'h4D5E6F70);
        enable = 1'b1;
        step();
        step();
        rst = 1'b1;
        @(negedge clk);
        chk("t6_rd_en_in_rst", 64'(rd_en), 64'd0);
        step();
        repeat (3) void'(exp_q.pop_front());
        @(negedge clk);
        chk("t6_valid", 64'(valid), 64'd0);
        chk("t6_rd_en", 64'(rd_en), 64'd0);
        chk("t6_cnt", 64'(cnt), 64'd0);
        chk("t6_sof", 64'(sof), 64'd0);
        chk("t6_byte", 64'(byte_dat), 64'd0);
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t6_reload", 64'(rd_en), 64'd1);
        @(negedge clk);
        chk("t6_first_byte", 64'(byte_dat), 64'h4D);
        chk("t6_first_sof", 64'(sof), 64'd1);
        drain("t6_drain", 50, 0);
        chk("t6_fifo_left", 64'(fifo_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
